// File: rtl/bit_slicer_cfg_seq.sv
// bit_slicer_cfg_seq
// Sequencer that configures a bit_slicer over its AXI4-Lite slave port. A start
// pulse captures cfg_data. The block then writes NUM_REGS consecutive 32-bit
// registers and reads each one back to compare it. It ends with a one-cycle
// done pulse and a sticky error status.
//
// Ports
//   ACLK, ARESETN        clock; asynchronous active-low reset
//   start                one-cycle request, sampled only in IDLE
//   cfg_data             register i value in bits [32*i+31:32*i]
//   busy                 high from the cycle after start is accepted until done
//   done                 one-cycle completion pulse (success or failure)
//   error                sticky failure flag, cleared on the next accepted start
//   err_code             00 timeout, 01 BRESP error, 10 RRESP error, 11 mismatch
//   err_index            register index at the failure
//   dbg_state            current FSM state (encoding of the S_* constants below)
//   M_AXI_*              AXI4-Lite master (AW, W, B, AR, R channels)
//
// Handshake semantics: a transfer happens on the rising ACLK edge where VALID and
// READY are both high. Once this block raises a VALID, it holds that VALID and its
// payload stable until the handshake. The only exceptions are a timeout and reset.
// READY outputs are raised only in the state that waits for the matching response.
// All outputs come straight from registers.
module bit_slicer_cfg_seq #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,   // only 32 is supported
    parameter int NUM_REGS = 4,              // 1..16
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic                                   start,
    input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic [1:0]                             err_code,
    output logic [IDX_W-1:0]                       err_index,
    output logic [2:0]                             dbg_state,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
    output logic [2:0]                             M_AXI_AWPROT,
    output logic                                   M_AXI_AWVALID,
    input  logic                                   M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
    output logic                                   M_AXI_WVALID,
    input  logic                                   M_AXI_WREADY,
    input  logic [1:0]                             M_AXI_BRESP,
    input  logic                                   M_AXI_BVALID,
    output logic                                   M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
    output logic [2:0]                             M_AXI_ARPROT,
    output logic                                   M_AXI_ARVALID,
    input  logic                                   M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
    input  logic [1:0]                             M_AXI_RRESP,
    input  logic                                   M_AXI_RVALID,
    output logic                                   M_AXI_RREADY
);
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    localparam logic [1:0] E_TIMEOUT  = 2'b00;
    localparam logic [1:0] E_BRESP    = 2'b01;
    localparam logic [1:0] E_RRESP    = 2'b10;
    localparam logic [1:0] E_MISMATCH = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    cfg_q [NUM_REGS];
    logic [DW-1:0]    cfg_d [NUM_REGS];
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [AW-1:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic             arvalid_q, arvalid_d, rready_q, rready_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [IDX_W-1:0] err_index_q, err_index_d;

    logic             fail;
    logic [1:0]       fail_code;
    logic             last_idx;
    logic             tmo_hit;
    logic [IDX_W-1:0] idx_inc;

    function automatic logic [AW-1:0] reg_addr(input logic [IDX_W-1:0] i);
        return BASE_ADDR + {{(AW-IDX_W-2){1'b0}}, i, 2'b00};
    endfunction

    assign last_idx = (idx_q == IDX_W'(NUM_REGS - 1));
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign idx_inc  = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cfg_d       = cfg_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        fail        = 1'b0;
        fail_code   = E_TIMEOUT;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_REGS; i++) cfg_d[i] = cfg_data[i*DW +: DW];
                    idx_d       = '0;
                    error_d     = 1'b0;
                    err_code_d  = 2'b00;
                    err_index_d = '0;
                    busy_d      = 1'b1;
                    awaddr_d    = reg_addr('0);
                    wdata_d     = cfg_data[DW-1:0];
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                // AW and W retire independently; a low VALID here means that
                // channel has already completed for this register.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = E_BRESP;
                    end else if (last_idx) begin
                        idx_d     = '0;
                        araddr_d  = reg_addr('0);
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end else begin
                        idx_d     = idx_inc;
                        awaddr_d  = reg_addr(idx_inc);
                        wdata_d   = cfg_q[idx_inc];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    // A bad response outranks a data compare on the same beat.
                    if (M_AXI_RRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = E_RRESP;
                    end else if (M_AXI_RDATA != cfg_q[idx_q]) begin
                        fail      = 1'b1;
                        fail_code = E_MISMATCH;
                    end else if (last_idx) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d     = idx_inc;
                        araddr_d  = reg_addr(idx_inc);
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            error_d     = 1'b1;
            err_code_d  = fail_code;
            err_index_d = idx_q;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            state_d     = S_FIN;
        end

        // The wait counter restarts on every state entry, including a re-entry
        // that comes through another state.
        if (state_d != state_q || state_q == S_IDLE || state_q == S_FIN) tmo_d = '0;
        else                                                          tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
            tmo_q       <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cfg_q       <= cfg_d;
            tmo_q       <= tmo_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign err_index     = err_index_q;
    assign dbg_state     = state_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_bit_slicer_cfg_seq.sv
// Testbench for bit_slicer_cfg_seq. An AXI4-Lite slave model runs on the falling
// edge. Directed scenarios cover nominal, backpressure, write error, mismatch,
// timeout, ignored start and mid-operation reset.
module tb_bit_slicer_cfg_seq;
  localparam int N = 4;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [N*32-1:0] CFG_NOM = {32'd4, 32'd3, 32'd2, 32'd1};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [N*32-1:0] cfg_data = '0;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [1:0] err_index;
  logic [2:0] dbg_state;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0] m_awprot, m_arprot;
  logic [3:0] m_wstrb;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0, s_arready = 1'b0, s_rvalid = 1'b0;
  logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // slave configuration (written only by the test tasks)
  int aw_delay = 0;
  bit bp_mode = 1'b0;
  bit ar_block = 1'b0;
  int bresp_err_idx = 15;
  int corrupt_idx = 15;

  // monitor results (written only by the slave process)
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, ar_high_cnt = 0, proto_err = 0, w_first_cnt = 0;
  logic [31:0] aw_addr_q[$], w_obs_q[$], ar_addr_q[$];

  // slave internal state
  logic [31:0] mem [16];
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got;
  logic [31:0] aw_hs_addr, w_hs_data, ar_hs_addr, wa, wd;
  int b_wait = -1, r_wait = -1, aw_wait = 0;
  logic [3:0] b_idx, r_idx;
  bit awv_prev, wv_prev, arv_prev;
  logic [31:0] awa_prev, wd_prev, ara_prev;

  bit_slicer_cfg_seq #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(N),
    .BASE_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .err_index(err_index), .dbg_state(dbg_state),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid),
    .M_AXI_WREADY(s_wready),
    .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(m_bready),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid),
    .M_AXI_RREADY(m_rready)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave model. Handshake flags computed at one falling edge describe the
  // transfer that occurs at the following rising edge; they are consumed at the
  // next falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
      s_arready = 0; s_rvalid = 0; s_rresp = 0; s_rdata = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; aw_got = 0; w_got = 0;
      b_wait = -1; r_wait = -1; aw_wait = 0;
      awv_prev = 0; wv_prev = 0; arv_prev = 0;
    end else begin
      if (awv_prev && !aw_hs && !error && (!m_awvalid || m_awaddr !== awa_prev)) proto_err++;
      if (wv_prev && !w_hs && !error && (!m_wvalid || m_wdata !== wd_prev)) proto_err++;
      if (arv_prev && !ar_hs && !error && (!m_arvalid || m_araddr !== ara_prev)) proto_err++;
      if (w_hs && !aw_hs && !aw_got) w_first_cnt++;
      if (aw_hs) begin
        aw_cnt++; aw_addr_q.push_back(aw_hs_addr); aw_got = 1; wa = aw_hs_addr;
        s_awready = 0; aw_wait = 0;
      end
      if (w_hs) begin
        w_cnt++; w_obs_q.push_back(w_hs_data); w_got = 1; wd = w_hs_data; s_wready = 0;
      end
      if (aw_got && w_got) begin
        mem[wa[5:2]] = wd; b_idx = wa[5:2]; aw_got = 0; w_got = 0;
        b_wait = bp_mode ? int'($urandom_range(0, 5)) : 0;
      end
      if (b_hs) s_bvalid = 0;
      if (b_wait == 0) begin
        s_bvalid = 1; s_bresp = (int'(b_idx) == bresp_err_idx) ? 2'b10 : 2'b00; b_wait = -1;
      end else if (b_wait > 0) b_wait--;
      if (m_awvalid && !s_awready && !aw_got) begin
        if (aw_wait >= aw_delay) s_awready = 1; else aw_wait++;
      end
      if (m_wvalid && !s_wready && !w_got) s_wready = 1;
      if (ar_hs) begin
        ar_cnt++; ar_addr_q.push_back(ar_hs_addr); r_idx = ar_hs_addr[5:2]; s_arready = 0;
        r_wait = bp_mode ? int'($urandom_range(0, 5)) : 0;
      end
      if (r_hs) s_rvalid = 0;
      if (r_wait == 0) begin
        s_rvalid = 1; s_rresp = 2'b00; r_wait = -1;
        s_rdata = (int'(r_idx) == corrupt_idx) ? 32'hDEADBEEF : mem[r_idx];
      end else if (r_wait > 0) r_wait--;
      if (m_arvalid && !s_arready && !ar_block) s_arready = 1;
      if (m_arvalid) ar_high_cnt++;
      aw_hs = m_awvalid && s_awready; aw_hs_addr = m_awaddr;
      w_hs = m_wvalid && s_wready; w_hs_data = m_wdata;
      b_hs = s_bvalid && m_bready;
      ar_hs = m_arvalid && s_arready; ar_hs_addr = m_araddr;
      r_hs = s_rvalid && m_rready;
      awv_prev = m_awvalid; awa_prev = m_awaddr;
      wv_prev = m_wvalid; wd_prev = m_wdata;
      arv_prev = m_arvalid; ara_prev = m_araddr;
    end
  end

  // driver task: pulse start, then count cycles until done (bounded)
  task automatic run_seq(input bit inject, output int lat, output bit got,
                         output logic err0, output int busy_bad);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    lat = 0; got = 1'b0; err0 = error; busy_bad = 0;
    while (lat < 400) begin
      if (done) begin got = 1'b1; break; end
      if (!busy) busy_bad++;
      if (inject && lat == 5) begin start = 1'b1; cfg_data = {N{32'hFFFF_FFFF}}; end
      if (inject && lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_vr: got %b expected 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    n_cmp++; if (m_awaddr !== 32'h0 || m_araddr !== 32'h0 || m_wdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_addr_data: got %h/%h/%h expected 0", m_awaddr, m_araddr, m_wdata); end
    n_cmp++; if ({busy, done, error} !== 3'b000) begin
      n_bad++; $display("FAIL reset_status: got %b expected 000", {busy, done, error}); end
    n_cmp++; if (err_code !== 2'b00 || err_index !== 2'b00) begin
      n_bad++; $display("FAIL reset_err: got %b/%0d expected 00/0", err_code, err_index); end
    n_cmp++; if (dbg_state !== 3'd0) begin
      n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_cmp++; if (m_awprot !== 3'd0 || m_arprot !== 3'd0 || m_wstrb !== 4'hF) begin
      n_bad++; $display("FAIL const_ports: got %b/%b/%h expected 000/000/f", m_awprot, m_arprot, m_wstrb); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int lat, bb, awb, wb, arb, awc, arc;
    bit got;
    logic e0;
    logic [31:0] exp;
    awb = aw_addr_q.size(); wb = w_obs_q.size(); arb = ar_addr_q.size();
    awc = aw_cnt; arc = ar_cnt;
    cfg_data = CFG_NOM;
    exp_q.delete();
    for (int i = 1; i <= N; i++) exp_q.push_back(32'(i));
    run_seq(1'b0, lat, got, e0, bb);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL nom_done: got %0d expected 1", got); end
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL nom_latency: got %0d expected 17", lat); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL nom_error: got %b expected 0", error); end
    n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL nom_busy: got %0d low cycles expected 0", bb); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL nom_done_pulse: got done=%b busy=%b expected 0/0", done, busy); end
    n_cmp++; if (aw_cnt - awc !== N || ar_cnt - arc !== N) begin
      n_bad++; $display("FAIL nom_counts: got aw=%0d ar=%0d expected 4/4", aw_cnt - awc, ar_cnt - arc); end
    for (int i = 0; i < N && awb + i < aw_addr_q.size() && arb + i < ar_addr_q.size(); i++) begin
      n_cmp++; if (aw_addr_q[awb+i] !== 32'(4*i) || ar_addr_q[arb+i] !== 32'(4*i)) begin
        n_bad++; $display("FAIL nom_addr%0d: got aw=%h ar=%h expected %h", i, aw_addr_q[awb+i], ar_addr_q[arb+i], 4*i); end
    end
    for (int i = 0; i < N && wb + i < w_obs_q.size(); i++) begin
      exp = exp_q.pop_front();
      n_cmp++; if (w_obs_q[wb+i] !== exp) begin
        n_bad++; $display("FAIL nom_wdata%0d: got %h expected %h", i, w_obs_q[wb+i], exp); end
    end
  endtask

  task automatic test_backpressure();
    int lat, bb, wb, awc, wc, arc, pe, wf;
    bit got;
    logic e0;
    logic [31:0] exp;
    wb = w_obs_q.size(); awc = aw_cnt; wc = w_cnt; arc = ar_cnt; pe = proto_err; wf = w_first_cnt;
    aw_delay = 3; bp_mode = 1'b1;
    cfg_data = CFG_NOM;
    exp_q.delete();
    for (int i = 1; i <= N; i++) exp_q.push_back(32'(i));
    run_seq(1'b0, lat, got, e0, bb);
    n_cmp++; if (got !== 1'b1 || error !== 1'b0) begin
      n_bad++; $display("FAIL bp_result: got done=%0d error=%b expected 1/0", got, error); end
    n_cmp++; if (aw_cnt - awc !== N || w_cnt - wc !== N || ar_cnt - arc !== N) begin
      n_bad++; $display("FAIL bp_counts: got aw=%0d w=%0d ar=%0d expected 4 each", aw_cnt - awc, w_cnt - wc, ar_cnt - arc); end
    n_cmp++; if (w_first_cnt - wf !== N) begin
      n_bad++; $display("FAIL bp_independent: got %0d early W expected 4", w_first_cnt - wf); end
    n_cmp++; if (proto_err - pe !== 0) begin
      n_bad++; $display("FAIL bp_stability: got %0d violations expected 0", proto_err - pe); end
    for (int i = 0; i < N && wb + i < w_obs_q.size(); i++) begin
      exp = exp_q.pop_front();
      n_cmp++; if (w_obs_q[wb+i] !== exp) begin
        n_bad++; $display("FAIL bp_wdata%0d: got %h expected %h", i, w_obs_q[wb+i], exp); end
    end
    aw_delay = 0; bp_mode = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_error();
    int lat, bb, awc, arc;
    bit got;
    logic e0;
    awc = aw_cnt; arc = ar_cnt;
    bresp_err_idx = 2;
    cfg_data = CFG_NOM;
    run_seq(1'b0, lat, got, e0, bb);
    n_cmp++; if (got !== 1'b1 || lat !== 7) begin
      n_bad++; $display("FAIL werr_done: got done=%0d lat=%0d expected 1/7", got, lat); end
    n_cmp++; if ({error, err_code, err_index} !== {1'b1, 2'b01, 2'd2}) begin
      n_bad++; $display("FAIL werr_status: got %b/%b/%0d expected 1/01/2", error, err_code, err_index); end
    n_cmp++; if (aw_cnt - awc !== 3 || ar_cnt - arc !== 0) begin
      n_bad++; $display("FAIL werr_no_more_aw: got aw=%0d ar=%0d expected 3/0", aw_cnt - awc, ar_cnt - arc); end
    bresp_err_idx = 15;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mismatch();
    int lat, bb, arc;
    bit got;
    logic e0;
    arc = ar_cnt;
    corrupt_idx = 1;
    cfg_data = CFG_NOM;
    run_seq(1'b0, lat, got, e0, bb);
    n_cmp++; if (got !== 1'b1 || lat !== 13) begin
      n_bad++; $display("FAIL mm_done: got done=%0d lat=%0d expected 1/13", got, lat); end
    n_cmp++; if ({error, err_code, err_index} !== {1'b1, 2'b11, 2'd1}) begin
      n_bad++; $display("FAIL mm_status: got %b/%b/%0d expected 1/11/1", error, err_code, err_index); end
    n_cmp++; if (ar_cnt - arc !== 2) begin
      n_bad++; $display("FAIL mm_no_ar2: got %0d AR expected 2", ar_cnt - arc); end
    corrupt_idx = 15;
    repeat (3) @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL mm_sticky: got %b expected 1", error); end
    run_seq(1'b0, lat, got, e0, bb);
    n_cmp++; if (e0 !== 1'b0) begin n_bad++; $display("FAIL mm_clear: got %b expected 0", e0); end
    n_cmp++; if (got !== 1'b1 || lat !== 17 || error !== 1'b0) begin
      n_bad++; $display("FAIL mm_rerun: got done=%0d lat=%0d error=%b expected 1/17/0", got, lat, error); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, bb, ahc, awc, arc;
    bit got;
    logic e0;
    ahc = ar_high_cnt; awc = aw_cnt; arc = ar_cnt;
    ar_block = 1'b1;
    cfg_data = CFG_NOM;
    run_seq(1'b0, lat, got, e0, bb);
    n_cmp++; if (got !== 1'b1 || lat !== 25) begin
      n_bad++; $display("FAIL tmo_done: got done=%0d lat=%0d expected 1/25", got, lat); end
    n_cmp++; if ({error, err_code, err_index} !== {1'b1, 2'b00, 2'd0}) begin
      n_bad++; $display("FAIL tmo_status: got %b/%b/%0d expected 1/00/0", error, err_code, err_index); end
    n_cmp++; if (ar_high_cnt - ahc !== 16 || m_arvalid !== 1'b0) begin
      n_bad++; $display("FAIL tmo_arvalid: got %0d cycles arvalid=%b expected 16/0", ar_high_cnt - ahc, m_arvalid); end
    n_cmp++; if (aw_cnt - awc !== N || ar_cnt - arc !== 0) begin
      n_bad++; $display("FAIL tmo_counts: got aw=%0d ar=%0d expected 4/0", aw_cnt - awc, ar_cnt - arc); end
    ar_block = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat, bb, wb, awc;
    bit got;
    logic e0;
    wb = w_obs_q.size(); awc = aw_cnt;
    cfg_data = CFG_NOM;
    run_seq(1'b1, lat, got, e0, bb);
    n_cmp++; if (got !== 1'b1 || lat !== 17 || error !== 1'b0) begin
      n_bad++; $display("FAIL ign_run: got done=%0d lat=%0d error=%b expected 1/17/0", got, lat, error); end
    for (int i = 0; i < N && wb + i < w_obs_q.size(); i++) begin
      n_cmp++; if (w_obs_q[wb+i] !== 32'(i + 1)) begin
        n_bad++; $display("FAIL ign_wdata%0d: got %h expected %h", i, w_obs_q[wb+i], i + 1); end
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (aw_cnt - awc !== N || busy !== 1'b0) begin
      n_bad++; $display("FAIL ign_no_restart: got aw=%0d busy=%b expected 4/0", aw_cnt - awc, busy); end
  endtask

  task automatic test_reset_midop();
    bit found;
    int awc;
    found = 1'b0;
    cfg_data = CFG_NOM;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (dbg_state === ST_WR_RESP && m_awaddr === 32'h4) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (found !== 1'b1 || m_bready !== 1'b1) begin
      n_bad++; $display("FAIL rst_reach_wr_resp1: got found=%0d bready=%b expected 1/1", found, m_bready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      n_bad++; $display("FAIL rst_async_vr: got %b expected 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    n_cmp++; if ({busy, done, error} !== 3'b000 || dbg_state !== 3'd0) begin
      n_bad++; $display("FAIL rst_async_status: got %b state=%0d expected 000/0", {busy, done, error}, dbg_state); end
    n_cmp++; if (m_awaddr !== 32'h0 || m_wdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_async_addr: got %h/%h expected 0/0", m_awaddr, m_wdata); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    awc = aw_cnt;
    repeat (10) @(negedge clk);
    n_cmp++; if (aw_cnt - awc !== 0 || m_awvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_no_resume: got aw=%0d awvalid=%b busy=%b expected 0/0/0", aw_cnt - awc, m_awvalid, busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_write_error();
    test_mismatch();
    test_timeout();
    test_start_ignored();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
